// File: rtl/cpu_pkg.sv
// Shared bus-side definitions: encoder code-width helper, default encoder size, handshake constants.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package cpu_pkg;

  // Default number of request lines on the bus-select encoder.
  localparam int PE_DEFAULT_N = 32;

  // {valid, ready} patterns seen on a bus-side valid/ready link.
  localparam logic [1:0] HS_IDLE  = 2'b00;
  localparam logic [1:0] HS_WAIT  = 2'b01;
  localparam logic [1:0] HS_STALL = 2'b10;
  localparam logic [1:0] HS_FIRE  = 2'b11;

  // Width of an index into n request lines; a single line still needs one bit.
  function automatic int pe_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_find_comb.sv
// Descending wrap-around search: first set bit of vec visiting start, start-1, ..., 0, N-1, ..., start+1.
// Latency: combinational.
// Backpressure: none; the result is consumed by the grant register of the caller.
module pe_find_comb
  import cpu_pkg::*;
#(
  parameter int N = PE_DEFAULT_N,
  localparam int W = pe_width(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  logic         lo_hit;
  logic         hi_hit;
  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;

  // Highest set bit at or below start wins; otherwise the highest set bit overall,
  // which then necessarily lies above start and is the first one reached after the wrap.
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        hi_hit = 1'b1;
        hi_idx = W'(i);
        if (i <= int'(start)) begin
          lo_hit = 1'b1;
          lo_idx = W'(i);
        end
      end
    end
    found = hi_hit;
    idx   = lo_hit ? lo_idx : hi_idx;
  end

endmodule

// File: rtl/pe_req_arbiter.sv
// Sticky, maskable request arbiter presenting one encoded winner at a time (optional PE_ROUND_ROBIN_EN).
// Latency: request sampled at edge k, earliest out_valid after edge k+1; accept and next grant share an edge.
// Backpressure: out_valid/out_code freeze while out_valid & !out_ready; requests keep accumulating in pending.
module pe_req_arbiter
  import cpu_pkg::*;
#(
  parameter int          N        = PE_DEFAULT_N,
  parameter logic [N-1:0] MASK_RST = {N{1'b1}},
  localparam int         W        = pe_width(N)
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic [N-1:0] req,
  input  logic         mask_we,
  input  logic [N-1:0] mask_wdata,
  output logic [N-1:0] mask_q,
  output logic [N-1:0] pending_q,
  output logic         out_valid,
  output logic [W-1:0] out_code,
  input  logic         out_ready
);

  logic         accept;
  logic         advance;
  logic [N-1:0] clr;
  logic [N-1:0] eligible;
  logic [W-1:0] start;
  logic         found;
  logic [W-1:0] win;

  assign accept  = out_valid & out_ready;
  assign advance = ~out_valid | out_ready;

  // One-hot of the code being accepted this cycle; empty when nothing is accepted.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = accept && (out_code == W'(i));
    end
  end

  // The index leaving this cycle is never re-granted on the same edge.
  assign eligible = pending_q & mask_q & ~clr;

`ifdef PE_ROUND_ROBIN_EN
  logic [W-1:0] rr_ptr;

  assign start = rr_ptr;

  // Search starts just below the last accepted index so every requester gets a turn.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rr_ptr <= W'(N - 1);
    end else if (accept) begin
      rr_ptr <= (out_code == '0) ? W'(N - 1) : out_code - W'(1);
    end
  end
`else
  assign start = W'(N - 1);
`endif

  pe_find_comb #(.N(N)) u_find (
    .vec   (eligible),
    .start (start),
    .found (found),
    .idx   (win)
  );

  // Pending bits are sticky until accepted; a request on the accept edge keeps the bit set.
  // The mask only gates eligibility and never drops a pending bit.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      pending_q <= '0;
      mask_q    <= MASK_RST;
    end else begin
      pending_q <= (pending_q & ~clr) | req;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end
    end
  end

  // Grant register: loads a new winner only when the output slot is empty or being drained.
  // With nothing eligible the code keeps its last value and only valid drops.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
    end else if (advance) begin
      out_valid <= found;
      if (found) begin
        out_code <= win;
      end
    end
  end

endmodule
